mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits directly downstream of the EXE/MEM pipeline register and consumes its outputs (mwreg, mm2reg, mwmem, mdestReg, mr, mqb).
- Holds the word-addressed data memory, which has a configurable access latency, and the MEM/WB pipeline register.
- Stalls upstream while a multi-cycle access is in flight. Flags misaligned accesses.

Parameters:
- AW, 8: data memory word-address width (2^AW 32-bit words).
- LAT, 2: extra wait cycles per load/store (0 = single-cycle memory).

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- mwreg  in  1  instruction writes a register
- mm2reg  in  1  instruction is a load
- mwmem  in  1  instruction is a store
- mdestReg  in  5  destination register number
- mr  in  32  ALU result / byte address
- mqb  in  32  store data
- mem_stall  out  1  hold PC, IF/ID, ID/EXE, EXE/MEM this cycle
- wwreg  out  1  WB register write enable
- wm2reg  out  1  WB select memory data
- wdestReg  out  5  WB destination register
- wr  out  32  WB ALU result
- wdo  out  32  WB load data
- wmisalign  out  1  misaligned access retired this cycle

Behaviour:
- Clock and reset: one clock, `clock`. Reset `resetn` is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - FSM goes to IDLE, wait counter to 0.
  - Data memory contents are not reset.
- Definitions:
  - access = (mm2reg | mwmem) & (mr[1:0] == 0).
  - misaligned = (mm2reg | mwmem) & (mr[1:0] != 0).
  - Memory index = mr[AW+1:2]. Bits above this are ignored, so addresses wrap modulo 2^AW words.
- FSM states: IDLE, WAIT, DONE. Counter width is sized to hold LAT.
- IDLE:
  - If access and LAT > 0:
    - mem_stall = 1, combinational in the same cycle.
    - Next state is DONE if LAT == 1; otherwise WAIT with cnt = LAT-2.
  - Otherwise: mem_stall = 0, and the instruction completes at this edge.
- WAIT:
  - mem_stall = 1.
  - If cnt == 0, go to DONE; else decrement cnt.
- DONE:
  - mem_stall = 0.
  - The held instruction completes at this edge. Next state is IDLE.
  - A new access is never restarted from DONE.
- Stall timing: an access first presented in cycle t has mem_stall high in cycles t..t+LAT-1 and low in cycle t+LAT. It completes at the edge ending cycle t+LAT.
- Upstream contract: upstream holds all inputs stable while mem_stall = 1.
- Completion edge:
  - If mwmem, the store writes mqb to memory.
  - If mm2reg, wdo captures the memory word.
  - wwreg, wm2reg, wdestReg and wr capture their inputs.
  - If mm2reg and mwmem are both set (illegal): the store is performed, and wdo receives the pre-store word.
- Stalled edges: MEM/WB inserts a bubble, meaning wwreg = 0 and wm2reg = 0. wdestReg, wr and wdo hold their values.
- Non-memory instructions: pass through in one cycle with no stall; wdo holds its value.
- Misaligned access:
  - No memory read or write, no stall.
  - At the completion edge: wwreg = 0, wm2reg = 0, wmisalign = 1. wmisalign is a one-cycle pulse; it is 0 on every other edge.
- Load after store: a load issued after a store to the same word returns the new data. The store commits at its completion edge, before the load reaches this stage.
- Reset mid-access:
  - FSM returns to IDLE and mem_stall drops immediately.
  - An uncommitted store is discarded.
  - After reset release, the instruction still present on the inputs is treated as a fresh access.

Test Plan:
- LAT=2. Store mr=0x10, mqb=0xDEADBEEF, then load mr=0x10, mwreg=1, mdestReg=5 -> each access gives mem_stall 1,1,0. Load retires wwreg=1, wm2reg=1, wdestReg=5, wdo=0xDEADBEEF. Bubble edges have wwreg=0.
- LAT=0. Back-to-back ALU ops (mr=1,2,3) and a load -> mem_stall stays 0. wr follows mr with 1-cycle latency.
- Load mr=0x13 -> no stall, wmisalign=1 for one cycle, wwreg=0. Memory is unchanged, verified by a later aligned load of 0x10.
- AW=8. Store to mr=0x400 (index 0) with 0x1234, then load mr=0 -> wdo=0x1234 (wrap).
- LAT=3. Assert resetn=0 during the second stall cycle of a store -> mem_stall=0 and outputs 0 immediately. After release, the store re-executes with a full 3-cycle stall and commits once.
- Non-memory instruction with mwreg=1, mdestReg=31, mr=0xFFFFFFFF -> wwreg=1, wdestReg=31, wr=0xFFFFFFFF, wdo unchanged, no stall.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: word-addressed data memory with a configurable access latency,
// the MEM/WB pipeline register, an upstream stall and misaligned-access flagging.
module mem_stage #(
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [4:0]  mdestReg,
    input  logic [31:0] mr,
    input  logic [31:0] mqb,
    output logic        mem_stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wdestReg,
    output logic [31:0] wr,
    output logic [31:0] wdo,
    output logic        wmisalign
);

    // The counter only has to hold LAT-2 (WAIT is entered after the IDLE stall cycle).
    localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((LAT >= 2) ? (LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          stall_raw;
    logic          complete;

    logic [31:0]   mem [0:(1<<AW)-1];

    logic          mem_op;
    logic          access;
    logic          misaligned;
    logic          mem_we;
    logic [AW-1:0] idx;

    assign mem_op     = mm2reg | mwmem;
    assign access     = mem_op & (mr[1:0] == 2'b00);
    assign misaligned = mem_op & (mr[1:0] != 2'b00);
    assign idx        = mr[AW+1:2];

    // Stall drops as soon as reset is asserted, even if an access sits on the inputs.
    assign mem_stall  = resetn & stall_raw;

    // A store commits only at its completion edge and never while reset is held.
    assign mem_we     = resetn & complete & mwmem & ~misaligned;

    // Latency FSM state and wait counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, stall and completion decode.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_raw  = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (access && (LAT > 0)) begin
                    stall_raw = 1'b1;
                    if (LAT == 1) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end else begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_DONE: begin
                // The held access retires here; a new access is never started from DONE.
                complete   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Data memory write port (contents are not reset).
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= mqb;
        end
    end

    // MEM/WB register: capture on completion, bubble on stalled edges.
    // The read sees the pre-write word, so a load+store pair returns the old data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wdestReg  <= '0;
            wr        <= '0;
            wdo       <= '0;
            wmisalign <= 1'b0;
        end else if (complete) begin
            wwreg     <= mwreg & ~misaligned;
            wm2reg    <= mm2reg & ~misaligned;
            wdestReg  <= mdestReg;
            wr        <= mr;
            wmisalign <= misaligned;
            if (mm2reg && !misaligned) begin
                wdo <= mem[idx];
            end
        end else begin
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wmisalign <= 1'b0;
        end
    end

endmodule
